// File: rtl/alu_issue_pkg.sv
// Shared decode constants and types for the single-issue ALU sequencer.
// Opcode/funct encodings are the RV32I OP and OP-IMM subset the ALU can execute.
package alu_issue_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_LSL = 3'd5,
      ALU_LSR = 3'd6
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } issue_state_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   function automatic logic [31:0] sext12(input logic [11:0] imm);
      return {{20{imm[11]}}, imm};
   endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Architectural integer register file: two combinational operand reads, one debug read,
// one synchronous write. x0 and out-of-range indices always read as zero.
module alu_issue_regfile #(
   parameter int NUM_REGS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rd1_addr,
   output logic [31:0] rd1_data,
   input  logic [4:0]  rd2_addr,
   output logic [31:0] rd2_data,
   input  logic [4:0]  dbg_addr,
   output logic [31:0] dbg_data,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [31:0] wr_data
);
   localparam int AW = $clog2(NUM_REGS);

   logic [31:0] regs [NUM_REGS];

   function automatic logic in_range(input logic [4:0] a);
      return (a != 5'd0) && ({1'b0, a} < 6'(NUM_REGS));
   endfunction

   assign rd1_data = in_range(rd1_addr) ? regs[rd1_addr[AW-1:0]] : 32'h0;
   assign rd2_data = in_range(rd2_addr) ? regs[rd2_addr[AW-1:0]] : 32'h0;
   assign dbg_data = in_range(dbg_addr) ? regs[dbg_addr[AW-1:0]] : 32'h0;

   // Writes to x0 fall out of in_range, so entry 0 only ever holds its reset value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'h0;
      end else if (wr_en && in_range(wr_addr)) begin
         regs[wr_addr[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/alu_issue.sv
// Single-issue execute sequencer: accepts RV32I OP/OP-IMM words, drives the registered ALU
// for one cycle, then writes its result back to rd.
//
//   state | meaning
//   IDLE  | ready for a new word; illegal words are flagged and dropped here
//   EXEC  | alu_ce high, ALU captures the result at the end of this cycle
//   WB    | ALU result written to rd; retire pulses on the following cycle
module alu_issue
   import alu_issue_pkg::*;
#(
   parameter int NUM_REGS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   output logic        alu_ce,
   output alu_op_t     alu_op,
   output logic [31:0] alu_operand1,
   output logic [31:0] alu_operand2,
   input  logic [31:0] alu_result,
   output logic        retire,
   output logic        illegal,
   input  logic [4:0]  dbg_rd_addr,
   output logic [31:0] dbg_rd_data
);
   localparam logic [5:0] REG_LIMIT = 6'(NUM_REGS);

   issue_state_t state, state_next;

   logic [6:0]  opcode;
   logic [4:0]  rd_f;
   logic [2:0]  funct3;
   logic [4:0]  rs1_f;
   logic [4:0]  rs2_f;
   logic [6:0]  funct7;
   logic [31:0] imm_sext;

   logic        accept;
   logic        dec_legal;
   logic        dec_ok;
   logic        dec_use_imm;
   logic        dec_shift;
   logic        idx_bad;
   alu_op_t     dec_op;
   logic [31:0] dec_operand2;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic        rf_we;
   logic [4:0]  rd_q;

   assign opcode   = in_instr[6:0];
   assign rd_f     = in_instr[11:7];
   assign funct3   = in_instr[14:12];
   assign rs1_f    = in_instr[19:15];
   assign rs2_f    = in_instr[24:20];
   assign funct7   = in_instr[31:25];
   assign imm_sext = sext12(in_instr[31:20]);

   // Operands are read while the word is still on the input; serial issue guarantees
   // the previous instruction's write-back has already landed.
   alu_issue_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .rd1_addr (rs1_f),
      .rd1_data (rs1_val),
      .rd2_addr (rs2_f),
      .rd2_data (rs2_val),
      .dbg_addr (dbg_rd_addr),
      .dbg_data (dbg_rd_data),
      .wr_en    (rf_we),
      .wr_addr  (rd_q),
      .wr_data  (alu_result)
   );

   always_comb begin
      dec_legal   = 1'b0;
      dec_op      = ALU_ADD;
      dec_use_imm = 1'b0;
      dec_shift   = 1'b0;
      case (opcode)
         OPC_OP: begin
            case (funct3)
               F3_ADD_SUB: begin
                  if (funct7 == F7_BASE) begin
                     dec_legal = 1'b1;
                  end else if (funct7 == F7_ALT) begin
                     dec_legal = 1'b1;
                     dec_op    = ALU_SUB;
                  end
               end
               F3_XOR: begin
                  dec_legal = (funct7 == F7_BASE);
                  dec_op    = ALU_XOR;
               end
               F3_OR: begin
                  dec_legal = (funct7 == F7_BASE);
                  dec_op    = ALU_OR;
               end
               F3_AND: begin
                  dec_legal = (funct7 == F7_BASE);
                  dec_op    = ALU_AND;
               end
               F3_SLL: begin
                  dec_legal = (funct7 == F7_BASE);
                  dec_op    = ALU_LSL;
                  dec_shift = 1'b1;
               end
               F3_SRL_SRA: begin
                  dec_legal = (funct7 == F7_BASE);
                  dec_op    = ALU_LSR;
                  dec_shift = 1'b1;
               end
               default: ;
            endcase
         end
         OPC_OP_IMM: begin
            dec_use_imm = 1'b1;
            case (funct3)
               F3_ADD_SUB: begin
                  dec_legal = 1'b1;
                  dec_op    = ALU_ADD;
               end
               F3_XOR: begin
                  dec_legal = 1'b1;
                  dec_op    = ALU_XOR;
               end
               F3_OR: begin
                  dec_legal = 1'b1;
                  dec_op    = ALU_OR;
               end
               F3_AND: begin
                  dec_legal = 1'b1;
                  dec_op    = ALU_AND;
               end
               F3_SLL: begin
                  dec_legal = (funct7 == F7_BASE);
                  dec_op    = ALU_LSL;
               end
               F3_SRL_SRA: begin
                  dec_legal = (funct7 == F7_BASE);
                  dec_op    = ALU_LSR;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   // The rs2 field is immediate bits for OP-IMM, so it is only range-checked for OP.
   assign idx_bad = ({1'b0, rs1_f} >= REG_LIMIT) || ({1'b0, rd_f} >= REG_LIMIT) ||
                    ((opcode == OPC_OP) && ({1'b0, rs2_f} >= REG_LIMIT));
   assign dec_ok  = dec_legal && !idx_bad;

   // The ALU shifts by its whole operand, so register shift amounts are trimmed here.
   always_comb begin
      dec_operand2 = rs2_val;
      if (dec_use_imm)    dec_operand2 = imm_sext;
      else if (dec_shift) dec_operand2 = {27'b0, rs2_val[4:0]};
   end

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      alu_ce     = 1'b0;
      rf_we      = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (accept && dec_ok) state_next = ST_EXEC;
         end
         ST_EXEC: begin
            alu_ce     = 1'b1;
            state_next = ST_WB;
         end
         ST_WB: begin
            rf_we      = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ALU controls are captured at accept and held until the next legal word.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_op       <= ALU_ADD;
         alu_operand1 <= 32'h0;
         alu_operand2 <= 32'h0;
         rd_q         <= 5'd0;
         retire       <= 1'b0;
         illegal      <= 1'b0;
      end else begin
         retire  <= rf_we;
         illegal <= accept && !dec_ok;
         if (accept && dec_ok) begin
            alu_op       <= dec_op;
            alu_operand1 <= rs1_val;
            alu_operand2 <= dec_operand2;
            rd_q         <= rd_f;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: registered ALU model, scoreboard of expected write-backs,
// plus a 16-register instance for the reduced register file.
module tb_alu_issue;
   import alu_issue_pkg::*;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] val;
   } sb_t;

   typedef struct {
      logic [31:0] instr;
      logic [4:0]  rd;
      logic [31:0] val;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = 32'h0;
   logic        alu_ce;
   alu_op_t     alu_op;
   logic [31:0] alu_operand1, alu_operand2;
   logic [31:0] alu_result = 32'h0;
   logic        retire, illegal;
   logic [4:0]  dbg_rd_addr = 5'd0;
   logic [31:0] dbg_rd_data;

   logic        in_valid16 = 1'b0;
   logic        in_ready16;
   logic [31:0] in_instr16 = 32'h0;
   logic        alu_ce16;
   alu_op_t     alu_op16;
   logic [31:0] alu_operand1_16, alu_operand2_16;
   logic [31:0] alu_result16 = 32'h0;
   logic        retire16, illegal16;
   logic [4:0]  dbg_rd_addr16 = 5'd0;
   logic [31:0] dbg_rd_data16;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int ce_cnt = 0, ret_cnt = 0, ill_cnt = 0;
   alu_op_t     ce_op = ALU_ADD;
   logic [31:0] ce_op1 = 32'h0, ce_op2 = 32'h0;
   sb_t sb_q[$];

   always #5 clk = ~clk;

   alu_issue #(.NUM_REGS(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .alu_ce(alu_ce), .alu_op(alu_op), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
      .alu_result(alu_result), .retire(retire), .illegal(illegal),
      .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data)
   );

   alu_issue #(.NUM_REGS(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .in_instr(in_instr16),
      .alu_ce(alu_ce16), .alu_op(alu_op16), .alu_operand1(alu_operand1_16),
      .alu_operand2(alu_operand2_16), .alu_result(alu_result16), .retire(retire16),
      .illegal(illegal16), .dbg_rd_addr(dbg_rd_addr16), .dbg_rd_data(dbg_rd_data16)
   );

   function automatic logic [31:0] alu_f(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         ALU_LSL: return a << b;
         ALU_LSR: return a >> b;
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (alu_ce)   alu_result   <= alu_f(alu_op, alu_operand1, alu_operand2);
      if (alu_ce16) alu_result16 <= alu_f(alu_op16, alu_operand1_16, alu_operand2_16);
   end

   always @(negedge clk) begin
      if (alu_ce) begin
         ce_cnt = ce_cnt + 1;
         ce_op  = alu_op;
         ce_op1 = alu_operand1;
         ce_op2 = alu_operand2;
      end
      if (retire)  ret_cnt = ret_cnt + 1;
      if (illegal) ill_cnt = ill_cnt + 1;
   end

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'b0010011};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   task automatic accept(input logic [31:0] w, input bit hold, output int waited);
      waited = 0;
      @(negedge clk);
      in_instr = w;
      in_valid = 1'b1;
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         tests_run++; tests_failed++;
         $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic wait_retire(output int lat, output bit seen);
      seen = 1'b0;
      lat  = -1;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         if (retire) begin
            seen = 1'b1;
            lat  = cyc - acc_cyc;
         end
      end
      #1;
   endtask

   task automatic run_instr(input logic [31:0] w, output int lat, output bit seen);
      int waited;
      accept(w, 1'b0, waited);
      wait_retire(lat, seen);
   endtask

   task automatic read_dbg(input logic [4:0] a, output logic [31:0] d);
      dbg_rd_addr = a;
      #1;
      d = dbg_rd_data;
   endtask

   task automatic drive16(input logic [31:0] w, output bit got_ill, output bit got_ret);
      got_ill = 1'b0;
      got_ret = 1'b0;
      @(negedge clk);
      in_instr16 = w;
      in_valid16 = 1'b1;
      for (int i = 0; i < 20 && !in_ready16; i++) @(negedge clk);
      @(posedge clk);
      #1;
      in_valid16 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (illegal16) got_ill = 1'b1;
         if (retire16)  got_ret = 1'b1;
         if (got_ret) break;
      end
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %0b, expected 1", in_ready); end
      tests_run++; if (alu_ce !== 1'b0) begin tests_failed++; $display("FAIL reset_alu_ce: got %0b, expected 0", alu_ce); end
      tests_run++; if (retire !== 1'b0 || illegal !== 1'b0) begin tests_failed++; $display("FAIL reset_pulses: retire=%0b illegal=%0b, expected 0 0", retire, illegal); end
      tests_run++; if (alu_op !== ALU_ADD) begin tests_failed++; $display("FAIL reset_alu_op: got %0d, expected %0d", alu_op, ALU_ADD); end
      tests_run++; if (alu_operand1 !== 32'h0 || alu_operand2 !== 32'h0) begin tests_failed++; $display("FAIL reset_operands: got %h %h, expected 0 0", alu_operand1, alu_operand2); end
      read_dbg(5'd31, d);
      tests_run++; if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_dbg_x31: got %h, expected 0", d); end
   endtask

   task automatic test_addi();
      int lat, ce0, r0;
      bit seen;
      sb_t e;
      logic [31:0] d;
      ce0 = ce_cnt;
      r0  = ret_cnt;
      sb_q.push_back('{5'd1, 32'd5});
      run_instr(enc_i(12'd5, 5'd0, 3'b000, 5'd1), lat, seen);
      tests_run++; if (!seen || lat != 2) begin tests_failed++; $display("FAIL addi_latency: seen=%0b latency=%0d, expected 1 2", seen, lat); end
      tests_run++; if (ce_cnt - ce0 != 1) begin tests_failed++; $display("FAIL addi_ce_cycles: got %0d, expected 1", ce_cnt - ce0); end
      tests_run++; if (ce_op !== ALU_ADD || ce_op1 !== 32'd0 || ce_op2 !== 32'd5) begin tests_failed++; $display("FAIL addi_alu_inputs: op=%0d a=%h b=%h, expected %0d 0 5", ce_op, ce_op1, ce_op2, ALU_ADD); end
      @(negedge clk);
      #1;
      tests_run++; if (ret_cnt - r0 != 1) begin tests_failed++; $display("FAIL addi_retire_pulse: got %0d pulses, expected 1", ret_cnt - r0); end
      e = sb_q.pop_front();
      read_dbg(e.rd, d);
      tests_run++; if (d !== e.val) begin tests_failed++; $display("FAIL addi_wb x%0d: got %h, expected %h", e.rd, d, e.val); end
   endtask

   task automatic test_back_to_back();
      int waited, lat, r0;
      bit seen;
      sb_t e;
      logic [31:0] d;
      r0 = ret_cnt;
      sb_q.push_back('{5'd2, 32'd10});
      sb_q.push_back('{5'd3, 32'hFFFF_FFFB});
      accept(enc_r(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd2), 1'b1, waited);
      accept(enc_r(7'b0100000, 5'd1, 5'd0, 3'b000, 5'd3), 1'b0, waited);
      tests_run++; if (waited != 2) begin tests_failed++; $display("FAIL b2b_ready_gap: waited %0d cycles, expected 2", waited); end
      wait_retire(lat, seen);
      tests_run++; if (!seen || lat != 2) begin tests_failed++; $display("FAIL b2b_latency: seen=%0b latency=%0d, expected 1 2", seen, lat); end
      tests_run++; if (ret_cnt - r0 != 2) begin tests_failed++; $display("FAIL b2b_retires: got %0d, expected 2", ret_cnt - r0); end
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         read_dbg(e.rd, d);
         tests_run++; if (d !== e.val) begin tests_failed++; $display("FAIL b2b_wb x%0d: got %h, expected %h", e.rd, d, e.val); end
      end
   endtask

   task automatic test_shifts();
      int lat;
      bit seen;
      sb_t e;
      logic [31:0] d;
      sb_q.push_back('{5'd5, 32'd33});
      run_instr(enc_i(12'd33, 5'd0, 3'b000, 5'd5), lat, seen);
      sb_q.push_back('{5'd6, 32'd10});
      run_instr(enc_r(7'b0000000, 5'd5, 5'd1, 3'b001, 5'd6), lat, seen);
      tests_run++; if (ce_op !== ALU_LSL || ce_op2 !== 32'd1) begin tests_failed++; $display("FAIL sll_trim: op=%0d b=%h, expected %0d 1", ce_op, ce_op2, ALU_LSL); end
      sb_q.push_back('{5'd7, 32'd40});
      run_instr(enc_i(12'd3, 5'd1, 3'b001, 5'd7), lat, seen);
      tests_run++; if (ce_op2 !== 32'd3) begin tests_failed++; $display("FAIL slli_shamt: got %h, expected 3", ce_op2); end
      sb_q.push_back('{5'd8, 32'hF});
      run_instr(enc_i(12'd28, 5'd3, 3'b101, 5'd8), lat, seen);
      tests_run++; if (ce_op !== ALU_LSR || ce_op1 !== 32'hFFFF_FFFB) begin tests_failed++; $display("FAIL srli_inputs: op=%0d a=%h, expected %0d fffffffb", ce_op, ce_op1, ALU_LSR); end
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         read_dbg(e.rd, d);
         tests_run++; if (d !== e.val) begin tests_failed++; $display("FAIL shift_wb x%0d: got %h, expected %h", e.rd, d, e.val); end
      end
   endtask

   task automatic test_logic();
      vec_t vecs[6];
      int lat;
      bit seen;
      sb_t e;
      logic [31:0] d;
      vecs[0] = '{enc_i(12'hFF0, 5'd1, 3'b110, 5'd10), 5'd10, 32'hFFFF_FFF5};
      vecs[1] = '{enc_i(12'h0F0, 5'd3, 3'b111, 5'd11), 5'd11, 32'h0000_00F0};
      vecs[2] = '{enc_r(7'b0000000, 5'd1, 5'd2, 3'b100, 5'd12), 5'd12, 32'd15};
      vecs[3] = '{enc_r(7'b0000000, 5'd6, 5'd3, 3'b111, 5'd13), 5'd13, 32'd10};
      vecs[4] = '{enc_r(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd14), 5'd14, 32'd15};
      vecs[5] = '{enc_i(12'hFFF, 5'd1, 3'b100, 5'd15), 5'd15, 32'hFFFF_FFFA};
      for (int i = 0; i < 6; i++) begin
         sb_q.push_back('{vecs[i].rd, vecs[i].val});
         run_instr(vecs[i].instr, lat, seen);
         tests_run++; if (!seen) begin tests_failed++; $display("FAIL logic_retire[%0d]: got 0, expected 1", i); end
         e = sb_q.pop_front();
         read_dbg(e.rd, d);
         tests_run++; if (d !== e.val) begin tests_failed++; $display("FAIL logic_wb x%0d: got %h, expected %h", e.rd, d, e.val); end
      end
   endtask

   task automatic test_illegal();
      logic [31:0] words[8];
      int waited, ce0, r0, i0;
      logic [31:0] d;
      words[0] = enc_r(7'b0100000, 5'd1, 5'd1, 3'b101, 5'd9);
      words[1] = {12'd0, 5'd0, 3'b010, 5'd9, 7'b0000011};
      words[2] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b010, 5'd9);
      words[3] = enc_i(12'd1, 5'd1, 3'b011, 5'd9);
      words[4] = enc_i({7'b0100000, 5'd2}, 5'd1, 3'b101, 5'd9);
      words[5] = enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd9);
      words[6] = enc_r(7'b0100000, 5'd2, 5'd1, 3'b100, 5'd9);
      words[7] = enc_i({7'b0000001, 5'd1}, 5'd1, 3'b001, 5'd9);
      for (int i = 0; i < 8; i++) begin
         ce0 = ce_cnt; r0 = ret_cnt; i0 = ill_cnt;
         accept(words[i], 1'b0, waited);
         @(negedge clk);
         tests_run++; if (illegal !== 1'b1 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL illegal_pulse[%0d]: illegal=%0b in_ready=%0b, expected 1 1", i, illegal, in_ready); end
         repeat (3) @(negedge clk);
         #1;
         tests_run++; if (ill_cnt - i0 != 1 || ce_cnt != ce0 || ret_cnt != r0) begin tests_failed++; $display("FAIL illegal_effects[%0d]: illegal=%0d ce=%0d retire=%0d, expected 1 0 0", i, ill_cnt - i0, ce_cnt - ce0, ret_cnt - r0); end
      end
      read_dbg(5'd9, d);
      tests_run++; if (d !== 32'h0) begin tests_failed++; $display("FAIL illegal_x9: got %h, expected 0", d); end
   endtask

   task automatic test_x0_and_rv32e();
      int lat;
      bit seen, got_ill, got_ret;
      sb_t e;
      logic [31:0] d;
      sb_q.push_back('{5'd0, 32'd0});
      run_instr(enc_i(12'd7, 5'd0, 3'b000, 5'd0), lat, seen);
      tests_run++; if (!seen) begin tests_failed++; $display("FAIL x0_retire: got 0, expected 1"); end
      e = sb_q.pop_front();
      read_dbg(e.rd, d);
      tests_run++; if (d !== e.val) begin tests_failed++; $display("FAIL x0_wb: got %h, expected %h", d, e.val); end

      drive16(enc_i(12'd1, 5'd0, 3'b000, 5'd20), got_ill, got_ret);
      tests_run++; if (!got_ill || got_ret) begin tests_failed++; $display("FAIL rv32e_rd20: illegal=%0b retire=%0b, expected 1 0", got_ill, got_ret); end
      drive16(enc_r(7'b0100000, 5'd16, 5'd1, 3'b000, 5'd1), got_ill, got_ret);
      tests_run++; if (!got_ill || got_ret) begin tests_failed++; $display("FAIL rv32e_rs2_16: illegal=%0b retire=%0b, expected 1 0", got_ill, got_ret); end
      sb_q.push_back('{5'd15, 32'd20});
      drive16(enc_i(12'd20, 5'd0, 3'b000, 5'd15), got_ill, got_ret);
      tests_run++; if (got_ill || !got_ret) begin tests_failed++; $display("FAIL rv32e_imm_field: illegal=%0b retire=%0b, expected 0 1", got_ill, got_ret); end
      e = sb_q.pop_front();
      dbg_rd_addr16 = e.rd;
      #1;
      tests_run++; if (dbg_rd_data16 !== e.val) begin tests_failed++; $display("FAIL rv32e_wb x%0d: got %h, expected %h", e.rd, dbg_rd_data16, e.val); end
      dbg_rd_addr16 = 5'd20;
      #1;
      tests_run++; if (dbg_rd_data16 !== 32'h0) begin tests_failed++; $display("FAIL rv32e_dbg20: got %h, expected 0", dbg_rd_data16); end
   endtask

   task automatic test_reset_in_wb();
      int waited, r0;
      logic [31:0] d;
      r0 = ret_cnt;
      accept(enc_i(12'd9, 5'd0, 3'b000, 5'd1), 1'b0, waited);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      tests_run++; if (retire !== 1'b0) begin tests_failed++; $display("FAIL rst_wb_retire: got %0b, expected 0", retire); end
      rst = 1'b0;
      @(negedge clk);
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_wb_in_ready: got %0b, expected 1", in_ready); end
      tests_run++; if (alu_op !== ALU_ADD || alu_operand2 !== 32'h0) begin tests_failed++; $display("FAIL rst_wb_alu_inputs: op=%0d b=%h, expected %0d 0", alu_op, alu_operand2, ALU_ADD); end
      repeat (2) @(negedge clk);
      #1;
      read_dbg(5'd1, d);
      tests_run++; if (d !== 32'h0) begin tests_failed++; $display("FAIL rst_wb_x1: got %h, expected 0", d); end
      tests_run++; if (ret_cnt != r0) begin tests_failed++; $display("FAIL rst_wb_no_retire: got %0d pulses, expected 0", ret_cnt - r0); end
      tests_run++; if (sb_q.size() != 0) begin tests_failed++; $display("FAIL scoreboard_left: %0d entries, expected 0", sb_q.size()); end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_back_to_back();
      test_shifts();
      test_logic();
      test_illegal();
      test_x0_and_rv32e();
      test_reset_in_wb();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
